float_vector_gather: RTL

//   Serial-to-parallel front end for the 16-lane float argmin tree.
//   - Accepts one SIZE-bit float per beat on an AXI-Stream slave.
//   - Packs beats into a LANES-wide vector and presents it on the master port in the tree's input format.
//   - Ping-pong double buffer: one vector is assembled while the previous one waits for downstream.
//   - Short vectors (tlast before lane LANES-1) are padded with PAD_VALUE so padded lanes never win argmin.

---
 rtl/float_vector_gather_if.sv | 26 ++
 rtl/float_vector_gather.sv | 78 +++++++
 2 files changed

// File: rtl/float_vector_gather_if.sv
// Stream bundle for float_vector_gather: scalar float beats in, packed lane vectors out.
interface float_vector_gather_if #(
  parameter int unsigned SIZE  = 64,
  parameter int unsigned LANES = 16
);
  localparam int unsigned CW = $clog2(LANES + 1);

  logic [SIZE-1:0]             s_axis_tdata;
  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic                        s_axis_tlast;
  logic [LANES-1:0][SIZE-1:0]  m_axis_tdata;
  logic [CW-1:0]               m_axis_tcount;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tcount, m_axis_tvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tcount, m_axis_tvalid
  );
endinterface

// File: rtl/float_vector_gather.sv
// Serial-to-parallel float gather with ping-pong banks feeding the argmin tree;
// short vectors are padded with PAD_VALUE so padded lanes never win.
module float_vector_gather #(
  parameter int unsigned     SIZE      = 64,
  parameter int unsigned     LANES     = 16,
  parameter logic [SIZE-1:0] PAD_VALUE = SIZE'(64'h7FF0_0000_0000_0000)
) (
  input  logic                  aclk,
  input  logic                  areset,
  float_vector_gather_if.slave  bus
);
  localparam int unsigned CW = $clog2(LANES + 1);
  localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [SIZE-1:0]            mem [2][LANES];
  logic [CW-1:0]              cnt [2];
  logic [1:0]                 full;
  logic                       wr_bank;
  logic                       rd_bank;
  logic [IW-1:0]              lane_idx;
  logic                       in_ready;
  logic                       accept;
  logic                       close;
  logic                       out_hs;
  logic [LANES-1:0][SIZE-1:0] vec;

  // Input readiness depends only on bank state and reset, never on downstream ready.
  assign in_ready = !full[wr_bank] && !areset;
  assign accept   = bus.s_axis_tvalid && in_ready;
  assign close    = accept && (bus.s_axis_tlast || (lane_idx == IW'(LANES - 1)));
  assign out_hs   = full[rd_bank] && bus.m_axis_tready;

  // Bank storage; contents are only exposed once a bank is marked full.
  always_ff @(posedge aclk) begin
    if (accept) begin
      mem[wr_bank][lane_idx] <= bus.s_axis_tdata;
      if (close) begin
        cnt[wr_bank] <= CW'(lane_idx) + CW'(1);
      end
    end
  end

  // Bank pointers and full flags; close and handshake always touch different banks.
  always_ff @(posedge aclk) begin
    if (areset) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      lane_idx <= '0;
    end else begin
      if (accept) begin
        lane_idx <= close ? '0 : lane_idx + IW'(1);
      end
      if (close) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= !wr_bank;
      end
      if (out_hs) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end

  // Lanes beyond the stored count read as padding, hiding stale data from older vectors.
  always_comb begin
    vec = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      vec[IW'(i)] = (CW'(i) < cnt[rd_bank]) ? mem[rd_bank][IW'(i)] : PAD_VALUE;
    end
  end

  assign bus.s_axis_tready = in_ready;
  assign bus.m_axis_tvalid = full[rd_bank];
  assign bus.m_axis_tcount = cnt[rd_bank];
  assign bus.m_axis_tdata  = vec;

endmodule
